// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

    // Frame sequencing states; PAR is only reachable when parity is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } piso_state_t;

    // Bit-index counter width for a given frame width (at least one bit).
    function automatic int unsigned piso_cw(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned PISO_DEF_WIDTH = 8;
    localparam int unsigned PISO_CW        = piso_cw(PISO_DEF_WIDTH);

endpackage

// File: rtl/piso_bit_counter.sv
// Data-bit index counter for one frame: cleared on load, advances on enable,
// saturates at WIDTH-1 and flags the last and next-to-last data bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = piso_cw(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_c_o,
    output logic pre_tc_c_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Terminal flags decoded from the current index.
    assign tc_c_o     = (count_q == CW'(WIDTH - 1));
    assign pre_tc_c_o = (count_q == CW'(WIDTH - 2));

    // Next index: load wins, otherwise count up without wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && !tc_c_o) begin
            count_d = count_q + CW'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and drives it one bit per clock on q, with back-to-back frame streaming.
// Build option: define PISO_PARITY_EN to add a trailing even-parity bit.
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             q_q, q_d;
    logic             qv_q, qv_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             cnt_load;
    logic             cnt_en;
    logic             tc;
    logic             pre_tc;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] shreg_rest;

    assign accept     = load_valid && ready_q;
    assign load_ready = ready_q;
    assign q          = q_q;
    assign q_valid    = qv_q;
    assign done       = done_q;

    // Bit-order selection: which bit goes out next and what remains to shift.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit  = din[WIDTH-1];
            next_bit   = shreg_q[WIDTH-1];
            din_rest   = {din[WIDTH-2:0], 1'b0};
            shreg_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit  = din[0];
            next_bit   = shreg_q[0];
            din_rest   = {1'b0, din[WIDTH-1:1]};
            shreg_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .tc_c_o    (tc),
        .pre_tc_c_o(pre_tc)
    );

    // Next-state and registered-output decode; an accept always opens a new frame.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        q_d      = 1'b0;
        qv_d     = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
            end
            SHIFT: begin
                if (!tc) begin
                    q_d     = next_bit;
                    qv_d    = 1'b1;
                    shreg_d = shreg_rest;
                    cnt_en  = 1'b1;
                    ready_d = pre_tc && !PAR_EN;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
                    q_d     = par_q;
                    qv_d    = 1'b1;
                    ready_d = 1'b1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = din_rest;
            q_d      = first_bit;
            qv_d     = 1'b1;
            ready_d  = 1'b0;
            cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
            par_d    = ^din;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity of the accepted word, held for the trailing parity cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
